// File: rtl/bsg_gateway_latency_link.sv
// Multi-channel link-latency emulator: per-channel FIFOs that delay each accepted word by a fixed cycle count.
// Optional random extra delay per word is enabled by defining BSG_GATEWAY_LATENCY_LINK_JITTER_EN.
module bsg_gateway_latency_link #(
    parameter int num_channels_p = 4,
    parameter int width_p        = 64,
    parameter int els_p          = 8,
    parameter int latency_p      = 4,
    parameter int jitter_bits_p  = 3
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,
    input  logic [num_channels_p*width_p-1:0]             data_i,
    input  logic [num_channels_p-1:0]                     v_i,
    output logic [num_channels_p-1:0]                     ready_and_o,
    output logic [num_channels_p*width_p-1:0]             data_o,
    output logic [num_channels_p-1:0]                     v_o,
    input  logic [num_channels_p-1:0]                     yumi_i,
    output logic [num_channels_p*$clog2(els_p+1)-1:0]     occupancy_o
);

    localparam int occ_w = $clog2(els_p + 1);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(latency_p + (1 << jitter_bits_p)) + 1;

    for (genvar c = 0; c < num_channels_p; c++) begin : chan
        logic [width_p-1:0] payload [els_p];
        logic [cnt_w-1:0]   count   [els_p];
        logic [ptr_w-1:0]   head, tail, head_next, tail_next;
        logic [occ_w-1:0]   occ;
        logic               has_room, valid, accept, deq;
        logic [cnt_w-1:0]   fresh;

        assign has_room  = occ < occ_w'(els_p);
        assign valid     = (occ != '0) && (count[head] == '0);
        assign accept    = reset_n_i & v_i[c] & has_room;
        assign deq       = yumi_i[c] & valid;
        assign head_next = (head == ptr_w'(els_p - 1)) ? '0 : head + ptr_w'(1);
        assign tail_next = (tail == ptr_w'(els_p - 1)) ? '0 : tail + ptr_w'(1);

`ifdef BSG_GATEWAY_LATENCY_LINK_JITTER_EN
        logic [15:0]      lfsr;
        logic [ptr_w-1:0] last;
        logic [cnt_w-1:0] last_left, base;

        // A new word never releases before the word queued just ahead of it, keeping FIFO order.
        assign last      = (tail == '0) ? ptr_w'(els_p - 1) : tail - ptr_w'(1);
        assign last_left = (occ == '0 || count[last] == '0) ? '0 : count[last] - cnt_w'(1);
        assign base      = cnt_w'(latency_p - 1) + cnt_w'(lfsr[jitter_bits_p-1:0]);
        assign fresh     = (base > last_left) ? base : last_left;

        always_ff @(posedge clk_i) begin
            if (!reset_n_i)
                lfsr <= 16'hACE1 ^ 16'(c);
            else
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
`else
        assign fresh = cnt_w'(latency_p - 1);
`endif

        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
                for (int i = 0; i < els_p; i++)
                    count[i] <= '0;
            end else begin
                // Stale slots also count down; they are overwritten before they matter.
                for (int i = 0; i < els_p; i++)
                    if (count[i] != '0)
                        count[i] <= count[i] - cnt_w'(1);
                if (accept) begin
                    count[tail] <= fresh;
                    tail        <= tail_next;
                end
                if (deq)
                    head <= head_next;
                if (accept && !deq)
                    occ <= occ + occ_w'(1);
                else if (!accept && deq)
                    occ <= occ - occ_w'(1);
            end
        end

        always_ff @(posedge clk_i) begin
            if (accept)
                payload[tail] <= data_i[c*width_p +: width_p];
        end

        assign v_o[c]                          = reset_n_i & valid;
        assign ready_and_o[c]                  = reset_n_i & has_room;
        assign data_o[c*width_p +: width_p]    = payload[head];
        assign occupancy_o[c*occ_w +: occ_w]   = reset_n_i ? occ : '0;

        assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i[c] |-> valid);
    end

endmodule

// File: tb/tb_bsg_gateway_latency_link.sv
// Self-checking bench for bsg_gateway_latency_link: queue-based release-time model plus directed and random traffic.
module tb_bsg_gateway_latency_link;

    localparam int NC  = 4;
    localparam int W   = 64;
    localparam int ELS = 8;
    localparam int LAT = 4;
    localparam int JB  = 3;
    localparam int OW  = $clog2(ELS + 1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NC*W-1:0]   data_in;
    logic [NC-1:0]     v_in;
    logic [NC-1:0]     ready;
    logic [NC*W-1:0]   data_out;
    logic [NC-1:0]     v_out;
    logic [NC-1:0]     yumi;
    logic [NC*OW-1:0]  occ;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W-1:0] mq_data [NC][$];
    int           mq_rel  [NC][$];
    logic [W-1:0] dval    [NC];

    always #5 clk = ~clk;

    bsg_gateway_latency_link #(
        .num_channels_p(NC), .width_p(W), .els_p(ELS), .latency_p(LAT), .jitter_bits_p(JB)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .data_i(data_in), .v_i(v_in), .ready_and_o(ready),
        .data_o(data_out), .v_o(v_out), .yumi_i(yumi), .occupancy_o(occ)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // A word is visible once the cycle count reaches its release time and it is at the front.
    function automatic bit exp_v(int c);
        return reset_n && mq_data[c].size() > 0 && cyc >= mq_rel[c][0];
    endfunction

    // Reference model: each accepted word is stamped with the cycle it must become visible.
    always @(posedge clk) begin
        cyc++;
        for (int c = 0; c < NC; c++) begin
            bit acc;
            if (!reset_n) begin
                mq_data[c].delete();
                mq_rel[c].delete();
            end else begin
                acc = v_in[c] && mq_data[c].size() < ELS;
                if (yumi[c] && mq_data[c].size() > 0) begin
                    void'(mq_data[c].pop_front());
                    void'(mq_rel[c].pop_front());
                end
                if (acc) begin
                    mq_data[c].push_back(data_in[c*W +: W]);
                    mq_rel[c].push_back(cyc + LAT - 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < NC; c++) begin
            checkOutput($sformatf("ready%0d", c), 64'(ready[c]), 64'(reset_n && mq_data[c].size() < ELS));
            checkOutput($sformatf("occ%0d", c), 64'(occ[c*OW +: OW]), reset_n ? 64'(mq_data[c].size()) : 64'd0);
`ifdef BSG_GATEWAY_LATENCY_LINK_JITTER_EN
            if (v_out[c]) begin
                checkOutput($sformatf("early%0d", c), 64'(exp_v(c)), 64'd1);
                if (mq_data[c].size() > 0)
                    checkOutput($sformatf("data%0d", c), data_out[c*W +: W], mq_data[c][0]);
            end else if (reset_n && mq_data[c].size() > 0) begin
                checkOutput($sformatf("late%0d", c), 64'(cyc >= mq_rel[c][0] + (1 << JB) - 1), 64'd0);
            end
`else
            checkOutput($sformatf("v%0d", c), 64'(v_out[c]), 64'(exp_v(c)));
            if (exp_v(c))
                checkOutput($sformatf("data%0d", c), data_out[c*W +: W], mq_data[c][0]);
`endif
        end
    end

    // Drives one cycle of inputs; sequential payloads advance only when the word will be taken.
    task automatic applyStimulus(input logic rst_n, input logic [NC-1:0] v, input logic [NC-1:0] ymask, input bit rnd);
        reset_n = rst_n;
        v_in    = v;
        for (int c = 0; c < NC; c++) begin
            if (rnd)
                dval[c] = {$urandom, $urandom};
            data_in[c*W +: W] = dval[c];
`ifdef BSG_GATEWAY_LATENCY_LINK_JITTER_EN
            yumi[c] = ymask[c] && rst_n && v_out[c];
`else
            yumi[c] = ymask[c] && rst_n && exp_v(c);
`endif
            if (!rnd && v[c] && rst_n && mq_data[c].size() < ELS)
                dval[c] = dval[c] + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runCycles(input int n, input logic rst_n, input logic [NC-1:0] v, input logic [NC-1:0] ymask, input bit rnd);
        repeat (n) begin
            applyStimulus(rst_n, v, ymask, rnd);
            tick();
        end
    endtask

    initial begin
        for (int c = 0; c < NC; c++) dval[c] = '0;
        reset_n = 1'b0;
        v_in    = '0;
        yumi    = '0;
        data_in = '0;

        runCycles(5, 1'b0, 4'hF, 4'h0, 1'b0);
        checkOutput("rst_v", 64'(v_out), 64'd0);
        checkOutput("rst_ready", 64'(ready), 64'd0);
        checkOutput("rst_occ", 64'(occ), 64'd0);

        dval[0] = 64'hA5;
        applyStimulus(1'b1, 4'b0001, 4'h0, 1'b0);
        tick();
        checkOutput("first_occ", 64'(occ[0 +: OW]), 64'd1);
        for (int k = 0; k < LAT; k++) begin
`ifndef BSG_GATEWAY_LATENCY_LINK_JITTER_EN
            checkOutput("lat_v0", 64'(v_out[0]), 64'(k == LAT - 1));
            if (k == LAT - 1) begin
                checkOutput("lat_data0", data_out[0 +: W], 64'hA5);
                checkOutput("lat_idle", 64'(v_out[NC-1:1]), 64'd0);
            end
`endif
            applyStimulus(1'b1, 4'h0, (k == LAT - 1) ? 4'b0001 : 4'h0, 1'b0);
            tick();
        end
        runCycles(12, 1'b1, 4'h0, 4'hF, 1'b0);

        dval[1] = '0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'b0010, 4'b0010, 1'b0);
            tick();
            checkOutput("stream_ready1", 64'(ready[1]), 64'd1);
        end
        runCycles(14, 1'b1, 4'h0, 4'hF, 1'b0);

        dval[2] = 64'd100;
        runCycles(13, 1'b1, 4'b0100, 4'h0, 1'b0);
        checkOutput("full_occ2", 64'(occ[2*OW +: OW]), 64'd8);
        checkOutput("full_ready2", 64'(ready[2]), 64'd0);
        checkOutput("full_head2", data_out[2*W +: W], 64'd100);
        applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b0);
        tick();
        checkOutput("after_yumi_occ2", 64'(occ[2*OW +: OW]), 64'd7);
        checkOutput("after_yumi_ready2", 64'(ready[2]), 64'd1);
        runCycles(8, 1'b1, 4'b0100, 4'b0100, 1'b0);
        runCycles(25, 1'b1, 4'h0, 4'hF, 1'b0);

        dval[3] = 64'd200;
        runCycles(3, 1'b1, 4'b1000, 4'h0, 1'b0);
        runCycles(12, 1'b1, 4'h0, 4'h0, 1'b0);
        checkOutput("simul_occ_before", 64'(occ[3*OW +: OW]), 64'd3);
        checkOutput("simul_v3", 64'(v_out[3]), 64'd1);
        applyStimulus(1'b1, 4'b1000, 4'b1000, 1'b0);
        tick();
        checkOutput("simul_occ_after", 64'(occ[3*OW +: OW]), 64'd3);
        checkOutput("simul_head3", data_out[3*W +: W], 64'd201);
        runCycles(20, 1'b1, 4'h0, 4'hF, 1'b0);

        dval[0] = 64'd300;
        runCycles(5, 1'b1, 4'b0001, 4'h0, 1'b0);
        checkOutput("midrst_occ_before", 64'(occ[0 +: OW]), 64'd5);
        applyStimulus(1'b0, 4'b0001, 4'h0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b0);
        checkOutput("midrst_occ", 64'(occ), 64'd0);
        checkOutput("midrst_v", 64'(v_out), 64'd0);
        runCycles(16, 1'b1, 4'h0, 4'hF, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 299) != 0), 4'($urandom), 4'($urandom), 1'b1);
            tick();
        end
        runCycles(30, 1'b1, 4'h0, 4'hF, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
